// File: rtl/add_sched_pkg.sv
// Shared types and constants for the multi-word add scheduler.
package add_sched_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } state_t;

    // Width of the word index; kept at least one bit wide.
    function automatic int k_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/add_sched_casqu.sv
// 32-bit carry-select adder: low half ripples, high half is precomputed
// for both carry values and selected by the low-half carry.
module casqu (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cin,
    output logic [31:0] sumo,
    output logic        cout
);

    logic [16:0] lo_sum;
    logic [16:0] hi_sum0;
    logic [16:0] hi_sum1;

    assign lo_sum  = {1'b0, x[15:0]}  + {1'b0, y[15:0]}  + {16'b0, cin};
    assign hi_sum0 = {1'b0, x[31:16]} + {1'b0, y[31:16]};
    assign hi_sum1 = {1'b0, x[31:16]} + {1'b0, y[31:16]} + 17'd1;

    assign sumo[15:0]          = lo_sum[15:0];
    assign {cout, sumo[31:16]} = lo_sum[16] ? hi_sum1 : hi_sum0;

endmodule

// File: rtl/add_sched.sv
// Round-robin scheduler sharing one 32-bit adder across two requesters;
// wide operands are added one word per cycle, LSW first.
module add_sched
    import add_sched_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [WORD_W*WORDS-1:0]   a0,
    input  logic [WORD_W*WORDS-1:0]   b0,
    input  logic                      cin0,
    input  logic [WORD_W*WORDS-1:0]   a1,
    input  logic [WORD_W*WORDS-1:0]   b1,
    input  logic                      cin1,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_id,
    output logic [WORD_W*WORDS-1:0]   rsp_sum,
    output logic                      rsp_cout,
    output logic                      busy
);

    localparam int W  = WORD_W * WORDS;
    localparam int KW = k_width(WORDS);
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            carry_q, carry_d;
    logic            last_q, last_d;
    logic            rsp_id_q, rsp_id_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [W-1:0]    sum_q, sum_d;

    logic [1:0]          grant;
    logic [WORD_W-1:0]   slice_a, slice_b, slice_sum;
    logic                slice_cout;

    // Tie goes to the requester that was not served last.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = (state_q == IDLE) ? grant : 2'b00;

    assign slice_a = op_a_q[int'(k_q)*WORD_W +: WORD_W];
    assign slice_b = op_b_q[int'(k_q)*WORD_W +: WORD_W];

    casqu u_casqu (
        .x    (slice_a),
        .y    (slice_b),
        .cin  (carry_q),
        .sumo (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        // NOTE: every next-state signal holds its value by default, so no path can infer a latch.
        state_d  = state_q;
        k_d      = k_q;
        carry_d  = carry_q;
        last_d   = last_q;
        rsp_id_d = rsp_id_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        sum_d    = sum_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    op_a_d   = grant[1] ? a1 : a0;
                    op_b_d   = grant[1] ? b1 : b0;
                    carry_d  = grant[1] ? cin1 : cin0;
                    rsp_id_d = grant[1];
                    k_d      = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                sum_d[int'(k_q)*WORD_W +: WORD_W] = slice_sum;
                carry_d = slice_cout;
                if (k_q == K_LAST) begin
                    state_d = RESP;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    last_d  = rsp_id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the operand and sum words are plain registers, reset here so an aborted job leaves no stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            carry_q  <= 1'b0;
            last_q   <= 1'b1;
            rsp_id_q <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sum_q    <= '0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            state_q  <= state_d;
            k_q      <= k_d;
            carry_q  <= carry_d;
            last_q   <= last_d;
            rsp_id_q <= rsp_id_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            sum_q    <= sum_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = carry_q;

endmodule

// File: tb/tb_add_sched.sv
// Directed and random checks of add_sched with WORDS=4 against a
// bench-side (W+1)-bit reference sum and a response scoreboard.
module tb_add_sched;
    import add_sched_pkg::*;

    localparam int WORDS  = 4;
    localparam int W      = WORD_W * WORDS;
    localparam int CW     = W + 8;
    localparam int N_RAND = 3000;

    logic           clk;
    logic           rst_n;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [W-1:0]   a0, b0, a1, b1;
    logic           cin0, cin1;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
    logic [W-1:0]   rsp_sum;

    add_sched #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a0        (a0),
        .b0        (b0),
        .cin0      (cin0),
        .a1        (a1),
        .b1        (b1),
        .cin1      (cin1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         id;
        logic [W:0]   res;
    } exp_t;

    int            total = 0;
    int            bad   = 0;
    exp_t          sb[$];
    int            grants[$];
    logic [1:0]    acc_s, ready_s;
    logic          rvalid_s, fire_s, rcout_s, rid_s;
    logic [W-1:0]  rsum_s;
    logic          held_v = 1'b0;
    logic [W+1:0]  held_val;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] r;
        for (int i = 0; i < WORDS; i++) r[i*WORD_W +: WORD_W] = $urandom;
        if ($urandom_range(0, 7) == 0) r = '1;
        return r;
    endfunction

    task automatic new_job(input int i);
        if (i == 0) begin
            a0 = rand_op(); b0 = rand_op(); cin0 = 1'($urandom_range(0, 1));
        end else begin
            a1 = rand_op(); b1 = rand_op(); cin1 = 1'($urandom_range(0, 1));
        end
    endtask

    // One clock: sample at negedge, check invariants and scoreboard, return at posedge+1.
    task automatic step();
        exp_t e;
        @(negedge clk);
        ready_s  = req_ready;
        rvalid_s = rsp_valid;
        rsum_s   = rsp_sum;
        rcout_s  = rsp_cout;
        rid_s    = rsp_id;
        acc_s    = req_valid & req_ready;
        fire_s   = rsp_valid & rsp_ready;
        chk("ready_onehot0", CW'($onehot0(req_ready)), CW'(1));
        chk("ready_outside_idle", CW'(busy & (|req_ready)), CW'(0));
        chk("ready_without_valid", CW'(req_ready & ~req_valid), CW'(0));
        if (held_v)
            chk("rsp_hold", CW'({rsp_valid, rsp_id, rsp_cout, rsp_sum}), CW'({1'b1, held_val}));
        if (acc_s[0]) begin
            e.id = 1'b0; e.res = {1'b0, a0} + {1'b0, b0} + {{W{1'b0}}, cin0};
            sb.push_back(e); grants.push_back(0);
        end
        if (acc_s[1]) begin
            e.id = 1'b1; e.res = {1'b0, a1} + {1'b0, b1} + {{W{1'b0}}, cin1};
            sb.push_back(e); grants.push_back(1);
        end
        if (fire_s) begin
            if (sb.size() == 0) begin
                chk("rsp_without_job", CW'(fire_s), CW'(0));
            end else begin
                e = sb.pop_front();
                chk("rsp_id", CW'(rsp_id), CW'(e.id));
                chk("rsp_result", CW'({rsp_cout, rsp_sum}), CW'(e.res));
            end
        end
        held_v   = rsp_valid & ~rsp_ready;
        held_val = {rsp_id, rsp_cout, rsp_sum};
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int i, input string tag);
        int n = 0;
        do begin step(); n++; end while (!acc_s[i] && n < 50);
        chk({tag, "_accept"}, CW'(acc_s[i]), CW'(1));
    endtask

    task automatic wait_rvalid(input string tag);
        int n = 0;
        do begin step(); n++; end while (!rvalid_s && n < 50);
        chk({tag, "_rsp_seen"}, CW'(rvalid_s), CW'(1));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin step(); n++; end
        chk({tag, "_drain"}, CW'(sb.size()), CW'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, CW'(req_ready), CW'(0));
        chk({tag, "_rsp_valid"}, CW'(rsp_valid), CW'(0));
        chk({tag, "_busy"},      CW'(busy),      CW'(0));
        chk({tag, "_rsp_id"},    CW'(rsp_id),    CW'(0));
        chk({tag, "_rsp_sum"},   CW'(rsp_sum),   CW'(0));
        chk({tag, "_rsp_cout"},  CW'(rsp_cout),  CW'(0));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        held_v = 1'b0; sb.delete(); grants.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int n;
        int done;
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        a0 = '0; b0 = '0; cin0 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

        // Reset state.
        #3;
        check_reset_outputs("rst");
        apply_reset();

        // Requester 0: all-ones + 0 + 1 wraps to zero with carry out.
        rsp_ready = 1'b1;
        a0 = '1; b0 = '0; cin0 = 1'b1; req_valid = 2'b01;
        wait_acc(0, "t1");
        req_valid = 2'b00;
        lat = 0;
        do begin step(); lat++; end while (!rvalid_s && lat < 20);
        chk("t1_latency", CW'(lat), CW'(WORDS + 1));
        chk("t1_sum",  CW'(rsum_s),  CW'(0));
        chk("t1_cout", CW'(rcout_s), CW'(1));
        chk("t1_id",   CW'(rid_s),   CW'(0));

        // Requester 1: carry crosses a word boundary.
        a1 = 128'h0000_0001_FFFF_FFFF_0000_0000_FFFF_FFFF;
        b1 = 128'h1; cin1 = 1'b0; req_valid = 2'b10;
        wait_acc(1, "t2");
        req_valid = 2'b00;
        wait_rvalid("t2");
        chk("t2_sum",  CW'(rsum_s),  CW'(128'h0000_0001_FFFF_FFFF_0000_0001_0000_0000));
        chk("t2_cout", CW'(rcout_s), CW'(0));
        chk("t2_id",   CW'(rid_s),   CW'(1));

        // Both requesters valid from reset: strict alternation starting at 0.
        apply_reset();
        rsp_ready = 1'b1;
        new_job(0); new_job(1); req_valid = 2'b11;
        n = 0;
        while (grants.size() < 4 && n < 200) begin
            step(); n++;
            for (int i = 0; i < 2; i++) if (acc_s[i]) new_job(i);
        end
        req_valid = 2'b00;
        drain("rr");
        chk("rr_grant_count", CW'(grants.size()), CW'(4));
        if (grants.size() >= 4)
            for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), CW'(grants[i]), CW'(i % 2));

        // Response back-pressure with requester 1 pending.
        rsp_ready = 1'b0;
        new_job(0); req_valid = 2'b01;
        wait_acc(0, "bp");
        req_valid = 2'b00;
        wait_rvalid("bp");
        new_job(1); req_valid = 2'b10;
        repeat (10) begin
            step();
            chk("bp_no_accept_in_resp", CW'(ready_s), CW'(0));
            chk("bp_valid_held", CW'(rvalid_s), CW'(1));
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_handshake", CW'(fire_s), CW'(1));
        chk("bp_no_accept_at_handshake", CW'(ready_s), CW'(0));
        step();
        chk("bp_accept_after_handshake", CW'(acc_s), CW'(2'b10));
        req_valid = 2'b00;
        drain("bp");

        // Abort mid-job: last job served was requester 0, so only reset restores last=1.
        new_job(0); req_valid = 2'b01;
        wait_acc(0, "ab0");
        req_valid = 2'b00;
        drain("ab0");
        new_job(1); req_valid = 2'b10;
        wait_acc(1, "ab1");
        req_valid = 2'b00;
        step();
        chk("ab_busy_mid_job", CW'(busy), CW'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("ab_async");
        sb.delete(); held_v = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (WORDS + 3) begin
            step();
            chk("ab_no_rsp", CW'(rvalid_s), CW'(0));
        end
        new_job(0); new_job(1); req_valid = 2'b11;
        step();
        chk("ab_grant_after_reset", CW'(acc_s), CW'(2'b01));
        req_valid = 2'b00;
        drain("ab2");

        // Random jobs with random request and response stalls.
        done = 0; n = 0;
        while (done < N_RAND && n < 60000) begin
            for (int i = 0; i < 2; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    new_job(i); req_valid[i] = 1'b1;
                end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step(); n++;
            if (fire_s) done++;
            for (int i = 0; i < 2; i++) if (acc_s[i]) req_valid[i] = 1'b0;
        end
        req_valid = 2'b00; rsp_ready = 1'b1;
        drain("rnd");
        chk("rnd_jobs_done", CW'(done), CW'(N_RAND));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
